eth_lb_frame_buf: RTL and testbench

- Store-and-forward loopback buffer between the mac_rgmii receive outputs and the mac_rgmii transmit inputs of one Ethernet channel.
- Replaces the per-channel register-stage loopback.
- Accepts only frames that close with eof. mac_rgmii raises eof only on good CRC, so bad-CRC frames are discarded.
- Optionally swaps destination and source MAC addresses, then replays each frame as one contiguous byte burst with a programmable inter-frame gap.

---
 rtl/eth_lb_frame_buf_pkg.sv | 24 ++
 rtl/eth_lb_frame_buf_if.sv | 17 +
 rtl/eth_lb_frame_buf_sdp_ram.sv | 25 ++
 rtl/eth_lb_frame_buf.sv | 194 +++++++++++++++++++
 tb/tb_eth_lb_frame_buf.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_lb_frame_buf_pkg.sv
// Shared types and helpers for the Ethernet loopback frame buffer.
package eth_lb_pkg;

   localparam int MAC_ADDR_LEN     = 6;
   localparam int MAC_HDR_SWAP_LEN = 12;

   typedef enum logic [1:0] {IDLE, PRIME, SEND, GAP} rd_state_t;
   typedef enum logic [1:0] {NOFRAME, INFRAME, DISCARD} wr_state_t;

   // Fields are sized for the largest supported RAM; the top truncates to its pointer width
   typedef struct packed {
      logic [15:0] base;
      logic [15:0] len;
   } desc_t;

   // Byte offset to read for output byte idx: exchanges the two MAC addresses when swap is set
   function automatic logic [15:0] hdr_map(input logic [15:0] idx, input logic swap);
      if (!swap)                             return idx;
      if (idx < 16'(MAC_ADDR_LEN))           return idx + 16'(MAC_ADDR_LEN);
      if (idx < 16'(MAC_HDR_SWAP_LEN))       return idx - 16'(MAC_ADDR_LEN);
      return idx;
   endfunction

endpackage

// File: rtl/eth_lb_frame_buf_if.sv
// RX byte stream in, TX byte stream out, as seen at the mac_rgmii boundary.
interface eth_lb_frame_buf_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_sof;
   logic       rx_eof;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_sof;
   logic       tx_eof;

   // The MAC side drives the receive stream and consumes the transmit stream
   modport master (output rx_data, rx_valid, rx_sof, rx_eof,
                   input  tx_data, tx_valid, tx_sof, tx_eof);
   modport slave  (input  rx_data, rx_valid, rx_sof, rx_eof,
                   output tx_data, tx_valid, tx_sof, tx_eof);
endinterface

// File: rtl/eth_lb_frame_buf_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module eth_lb_sdp_ram
   import eth_lb_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);
   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;

   // Write and registered read; no reset so the array maps onto block RAM
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/eth_lb_frame_buf.sv
// Store-and-forward loopback: buffers good frames from RX, replays them on TX.
module eth_lb_frame_buf
   import eth_lb_pkg::*;
#(
   parameter int DEPTH      = 4096,
   parameter int DESC_DEPTH = 16,
   parameter int MIN_LEN    = 14,
   parameter int IFG_CYCLES = 12
) (
   input  logic              clk,
   input  logic              rstn,
   eth_lb_frame_buf_if.slave bus,
   input  logic              swap_en,
   output logic [15:0]       frm_fwd_cnt,
   output logic [15:0]       frm_drop_cnt,
   output logic              ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int QW = $clog2(DESC_DEPTH);
   // IDLE and PRIME are already idle on the wire, so GAP only supplies the remainder
   localparam int GAP_LEN = (IFG_CYCLES > 2) ? IFG_CYCLES - 2 : 0;

   wr_state_t     r_wr_state;
   logic [PW-1:0] r_wr_ptr, r_frm_base, r_wr_len, r_rel_ptr;
   logic [15:0]   r_drop_cnt, r_fwd_cnt, r_gap_cnt;
   logic          r_ovf;
   desc_t         r_desc [DESC_DEPTH];
   logic [QW:0]   r_dq_wr, r_dq_rd;

   rd_state_t     r_rd_state;
   logic [PW-1:0] r_base, r_len, r_rd_idx, r_out_idx;
   logic          r_swap;
   logic [7:0]    r_tx_data;
   logic          r_tx_valid, r_tx_sof, r_tx_eof;

   logic          w_open, w_sof, w_accept, w_ram_full, w_write, w_bad, w_eof;
   logic          w_frame_bad, w_dq_full, w_dq_empty, w_commit, w_drop, w_abort;
   logic [PW-1:0] w_start_ptr, w_used, w_len_new;
   logic [AW-1:0] w_rd_addr;
   logic [7:0]    w_rdata;
   desc_t         w_head;
   logic [16:0]   w_drop_sum;

   // ---------------- write side ----------------
   assign w_open      = (r_wr_state != NOFRAME);
   assign w_sof       = bus.rx_valid & bus.rx_sof;
   // A sof restarts at frm_base, discarding whatever the open frame had written
   assign w_start_ptr = w_sof ? r_frm_base : r_wr_ptr;
   assign w_used      = w_start_ptr - r_rel_ptr;
   assign w_ram_full  = (w_used == PW'(DEPTH));
   assign w_len_new   = (w_sof ? '0 : r_wr_len) + PW'(1);
   assign w_accept    = bus.rx_valid & (bus.rx_sof | (r_wr_state == INFRAME));
   assign w_write     = w_accept & ~w_ram_full;
   assign w_bad       = w_accept & w_ram_full;
   assign w_eof       = bus.rx_valid & bus.rx_eof & (bus.rx_sof | w_open);
   assign w_frame_bad = w_bad | ((r_wr_state == DISCARD) & ~w_sof);
   assign w_dq_full   = (r_dq_wr[QW] != r_dq_rd[QW]) && (r_dq_wr[QW-1:0] == r_dq_rd[QW-1:0]);
   assign w_dq_empty  = (r_dq_wr == r_dq_rd);
   assign w_commit    = w_eof & ~w_frame_bad & ~w_dq_full &
                        (w_len_new >= PW'(MIN_LEN)) & (w_len_new <= PW'(DEPTH));
   assign w_drop      = w_eof & ~w_commit;
   assign w_abort     = w_sof & w_open;
   // Abort of the old frame and drop of a 1-byte new frame can land in the same cycle
   assign w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_abort) + 17'(w_drop);

   // Write-side frame tracking, drop accounting and descriptor push
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_state <= NOFRAME;
         r_wr_ptr   <= '0;
         r_frm_base <= '0;
         r_wr_len   <= '0;
         r_dq_wr    <= '0;
         r_drop_cnt <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_ovf      <= w_drop & (w_frame_bad | w_dq_full);
         r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
         if (w_commit) begin
            r_wr_ptr   <= w_start_ptr + PW'(1);
            r_frm_base <= w_start_ptr + PW'(1);
            r_dq_wr    <= r_dq_wr + (QW+1)'(1);
            r_wr_state <= NOFRAME;
         end else if (w_drop) begin
            r_wr_ptr   <= r_frm_base;
            r_wr_state <= NOFRAME;
         end else if (w_write) begin
            r_wr_ptr   <= w_start_ptr + PW'(1);
            r_wr_len   <= w_len_new;
            r_wr_state <= INFRAME;
         end else if (w_bad) begin
            r_wr_ptr   <= w_start_ptr;
            r_wr_state <= DISCARD;
         end
      end
   end

   // Descriptor storage; base is frm_base because a sof restarts there too
   always_ff @(posedge clk) begin
      if (w_commit) r_desc[r_dq_wr[QW-1:0]] <= '{base: 16'(r_frm_base), len: 16'(w_len_new)};
   end

   // ---------------- read side ----------------
   assign w_head = r_desc[r_dq_rd[QW-1:0]];

   // In IDLE byte 0 is addressed straight from the FIFO head so PRIME can hand it to TX
   always_comb begin
      if (r_rd_state == IDLE) w_rd_addr = AW'(w_head.base + hdr_map(16'd0, swap_en));
      else                    w_rd_addr = AW'(r_base + PW'(hdr_map(16'(r_rd_idx), r_swap)));
   end

   eth_lb_sdp_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .i_we    (w_write),
      .i_waddr (w_start_ptr[AW-1:0]),
      .i_wdata (bus.rx_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata)
   );

   // Replay FSM: pop, prime the RAM pipeline, stream len bytes, then hold the gap
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_state <= IDLE;
         r_dq_rd    <= '0;
         r_rel_ptr  <= '0;
         r_base     <= '0;
         r_len      <= '0;
         r_rd_idx   <= '0;
         r_out_idx  <= '0;
         r_swap     <= 1'b0;
         r_gap_cnt  <= '0;
         r_fwd_cnt  <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_tx_sof   <= 1'b0;
         r_tx_eof   <= 1'b0;
      end else begin
         case (r_rd_state)
            IDLE: begin
               if (!w_dq_empty) begin
                  r_dq_rd    <= r_dq_rd + (QW+1)'(1);
                  r_base     <= PW'(w_head.base);
                  r_len      <= PW'(w_head.len);
                  r_swap     <= swap_en;
                  r_rd_idx   <= PW'(1);
                  r_rd_state <= PRIME;
               end
            end
            PRIME: begin
               r_rd_idx   <= r_rd_idx + PW'(1);
               r_out_idx  <= '0;
               r_tx_data  <= w_rdata;
               r_tx_valid <= 1'b1;
               r_tx_sof   <= 1'b1;
               r_tx_eof   <= (r_len == PW'(1));
               r_rd_state <= SEND;
            end
            SEND: begin
               if (r_tx_eof) begin
                  r_tx_data  <= '0;
                  r_tx_valid <= 1'b0;
                  r_tx_sof   <= 1'b0;
                  r_tx_eof   <= 1'b0;
                  r_rel_ptr  <= r_base + r_len;
                  if (r_fwd_cnt != 16'hFFFF) r_fwd_cnt <= r_fwd_cnt + 16'd1;
                  r_gap_cnt  <= '0;
                  r_rd_state <= (GAP_LEN == 0) ? IDLE : GAP;
               end else begin
                  r_rd_idx   <= r_rd_idx + PW'(1);
                  r_out_idx  <= r_out_idx + PW'(1);
                  r_tx_data  <= w_rdata;
                  r_tx_sof   <= 1'b0;
                  r_tx_eof   <= ((r_out_idx + PW'(2)) == r_len);
               end
            end
            GAP: begin
               if (r_gap_cnt == 16'(GAP_LEN - 1)) r_rd_state <= IDLE;
               else                               r_gap_cnt  <= r_gap_cnt + 16'd1;
            end
            default: r_rd_state <= IDLE;
         endcase
      end
   end

   assign bus.tx_data   = r_tx_data;
   assign bus.tx_valid  = r_tx_valid;
   assign bus.tx_sof    = r_tx_sof;
   assign bus.tx_eof    = r_tx_eof;
   assign frm_fwd_cnt   = r_fwd_cnt;
   assign frm_drop_cnt  = r_drop_cnt;
   assign ovf           = r_ovf;
endmodule

// File: tb/tb_eth_lb_frame_buf.sv
// Directed bench: dut_a is the default configuration, dut_b a 256-byte RAM with a long gap.
module tb_eth_lb_frame_buf;

   typedef struct {
      int start;
      int sof_cyc;
      int eof_cyc;
      int n;
   } frec_t;

   logic        clk = 1'b0;
   logic        rstn_a, rstn_b, swap_a, swap_b;
   logic [15:0] fwd_a, drop_a, fwd_b, drop_b;
   logic        ovf_a, ovf_b;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   logic [7:0]  cap_a[$];
   logic [7:0]  cap_b[$];
   frec_t       fr_a[$];
   frec_t       fr_b[$];
   int          st_a, sofc_a, st_b, sofc_b;
   int          ovf_cnt_a = 0;
   int          ovf_cnt_b = 0;

   eth_lb_frame_buf_if bus_a ();
   eth_lb_frame_buf_if bus_b ();

   eth_lb_frame_buf #(.DEPTH(4096), .DESC_DEPTH(16), .MIN_LEN(14), .IFG_CYCLES(12)) dut_a (
      .clk(clk), .rstn(rstn_a), .bus(bus_a), .swap_en(swap_a),
      .frm_fwd_cnt(fwd_a), .frm_drop_cnt(drop_a), .ovf(ovf_a));

   eth_lb_frame_buf #(.DEPTH(256), .DESC_DEPTH(16), .MIN_LEN(14), .IFG_CYCLES(400)) dut_b (
      .clk(clk), .rstn(rstn_b), .bus(bus_b), .swap_en(swap_b),
      .frm_fwd_cnt(fwd_b), .frm_drop_cnt(drop_b), .ovf(ovf_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // TX capture for dut_a: byte stream plus one record per completed frame
   always @(negedge clk) begin
      frec_t r;
      if (bus_a.tx_valid) begin
         if (bus_a.tx_sof) begin st_a = cap_a.size(); sofc_a = cyc; end
         cap_a.push_back(bus_a.tx_data);
         if (bus_a.tx_eof) begin
            r.start = st_a; r.sof_cyc = sofc_a; r.eof_cyc = cyc; r.n = cap_a.size() - st_a;
            fr_a.push_back(r);
            $display("dut_a tx frame %0d: %0d bytes, sof@%0d eof@%0d", fr_a.size(), r.n, r.sof_cyc, r.eof_cyc);
         end
      end
      if (ovf_a) ovf_cnt_a++;
   end

   // TX capture for dut_b
   always @(negedge clk) begin
      frec_t r;
      if (bus_b.tx_valid) begin
         if (bus_b.tx_sof) begin st_b = cap_b.size(); sofc_b = cyc; end
         cap_b.push_back(bus_b.tx_data);
         if (bus_b.tx_eof) begin
            r.start = st_b; r.sof_cyc = sofc_b; r.eof_cyc = cyc; r.n = cap_b.size() - st_b;
            fr_b.push_back(r);
            $display("dut_b tx frame %0d: %0d bytes, sof@%0d eof@%0d", fr_b.size(), r.n, r.sof_cyc, r.eof_cyc);
         end
      end
      if (ovf_b) ovf_cnt_b++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Frame content as sent: dst 01..06, src 11..16, payload seed+i
   function automatic logic [7:0] orig_byte(input int j, input int seed);
      if (j < 6)  return 8'(32'h01 + j);
      if (j < 12) return 8'(32'h11 + j - 6);
      return 8'(seed + j);
   endfunction

   function automatic logic [7:0] exp_byte(input int i, input int seed, input bit swp);
      int j;
      j = i;
      if (swp) begin
         if (i < 6)       j = i + 6;
         else if (i < 12) j = i - 6;
      end
      return orig_byte(j, seed);
   endfunction

   // Index of the first wrong byte of a captured frame, or -1 when it matches
   function automatic int first_bad(input bit b, input int start, input int len, input int seed, input bit swp);
      logic [7:0] got;
      for (int i = 0; i < len; i++) begin
         if (b) got = (start + i < cap_b.size()) ? cap_b[start + i] : 8'hxx;
         else   got = (start + i < cap_a.size()) ? cap_a[start + i] : 8'hxx;
         if (got !== exp_byte(i, seed, swp)) return i;
      end
      return -1;
   endfunction

   task automatic drive(input bit b, input logic [7:0] d, input logic v, input logic s, input logic e);
      if (b) begin
         bus_b.rx_data = d; bus_b.rx_valid = v; bus_b.rx_sof = s; bus_b.rx_eof = e;
      end else begin
         bus_a.rx_data = d; bus_a.rx_valid = v; bus_a.rx_sof = s; bus_a.rx_eof = e;
      end
   endtask

   // One frame on RX; eof_cyc is the cycle in which the eof byte is presented
   task automatic send(input bit b, input int len, input int seed, input bit with_eof, output int eof_cyc);
      eof_cyc = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         drive(b, orig_byte(i, seed), 1'b1, (i == 0), with_eof && (i == len - 1));
         if (i == len - 1) eof_cyc = cyc;
      end
      @(negedge clk);
      drive(b, 8'h00, 1'b0, 1'b0, 1'b0);
      $display("dut_%s rx frame: %0d bytes seed %0d eof=%0d", b ? "b" : "a", len, seed, with_eof);
   endtask

   task automatic wait_frames(input bit b, input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (((b ? fr_b.size() : fr_a.size()) < n) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check(tag, b ? fr_b.size() : fr_a.size(), n);
   endtask

   initial begin
      int c, k;
      frec_t f, g;

      rstn_a = 1'b0; rstn_b = 1'b0; swap_a = 1'b0; swap_b = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("rst tx_valid", 32'(bus_a.tx_valid), 0);
      check("rst tx_sof",   32'(bus_a.tx_sof), 0);
      check("rst tx_eof",   32'(bus_a.tx_eof), 0);
      check("rst tx_data",  32'(bus_a.tx_data), 0);
      check("rst fwd_cnt",  32'(fwd_a), 0);
      check("rst drop_cnt", 32'(drop_a), 0);
      check("rst ovf",      32'(ovf_a), 0);
      rstn_a = 1'b1; rstn_b = 1'b1;
      repeat (2) @(negedge clk);

      // 64-byte frame replayed with MAC swap
      swap_a = 1'b1;
      send(1'b0, 64, 32, 1'b1, c);
      wait_frames(1'b0, 1, 300, "t1 frame count");
      f = fr_a[0];
      check("t1 sof latency", f.sof_cyc - c, 3);
      check("t1 length", f.n, 64);
      check("t1 contiguous", f.eof_cyc - f.sof_cyc, 63);
      check("t1 first bad byte", first_bad(1'b0, f.start, 64, 32, 1'b1), -1);
      check("t1 fwd_cnt", 32'(fwd_a), 1);

      // Two frames back to back, no swap: exact copies, 12-cycle gap between them
      swap_a = 1'b0;
      send(1'b0, 64, 64, 1'b1, c);
      send(1'b0, 64, 96, 1'b1, k);
      wait_frames(1'b0, 3, 600, "t2 frame count");
      f = fr_a[1];
      g = fr_a[2];
      check("t2 sof latency", f.sof_cyc - c, 3);
      check("t2 frame1 first bad byte", first_bad(1'b0, f.start, 64, 64, 1'b0), -1);
      check("t2 frame2 length", g.n, 64);
      check("t2 frame2 first bad byte", first_bad(1'b0, g.start, 64, 96, 1'b0), -1);
      check("t2 idle gap", g.sof_cyc - f.eof_cyc - 1, 12);
      check("t2 fwd_cnt", 32'(fwd_a), 3);

      // Unterminated 40-byte frame aborted by the next sof
      send(1'b0, 40, 128, 1'b0, c);
      send(1'b0, 60, 160, 1'b1, c);
      wait_frames(1'b0, 4, 300, "t3 frame count");
      f = fr_a[3];
      check("t3 length", f.n, 60);
      check("t3 first bad byte", first_bad(1'b0, f.start, 60, 160, 1'b0), -1);
      check("t3 drop_cnt", 32'(drop_a), 1);
      check("t3 fwd_cnt", 32'(fwd_a), 4);

      // Runt frame is dropped without ovf
      send(1'b0, 10, 5, 1'b1, c);
      repeat (40) @(negedge clk);
      check("t4 nothing sent", fr_a.size(), 4);
      check("t4 drop_cnt", 32'(drop_a), 2);
      check("t4 ovf pulses", ovf_cnt_a, 0);

      // Small RAM: filler moves the pointers, then three frames while TX sits in its gap
      send(1'b1, 100, 1, 1'b1, c);
      wait_frames(1'b1, 1, 400, "t5 filler sent");
      send(1'b1, 100, 2, 1'b1, c);
      send(1'b1, 100, 3, 1'b1, c);
      send(1'b1, 100, 4, 1'b1, c);
      wait_frames(1'b1, 3, 2500, "t5 frame count");
      repeat (600) @(negedge clk);
      f = fr_b[1];
      g = fr_b[2];
      check("t5 third not replayed", fr_b.size(), 3);
      check("t5 drop_cnt", 32'(drop_b), 1);
      check("t5 ovf pulses", ovf_cnt_b, 1);
      check("t5 frameA length", f.n, 100);
      check("t5 frameA first bad byte", first_bad(1'b1, f.start, 100, 2, 1'b0), -1);
      check("t5 frameB length", g.n, 100);
      check("t5 frameB wrap first bad byte", first_bad(1'b1, g.start, 100, 3, 1'b0), -1);
      check("t5 fwd_cnt", 32'(fwd_b), 3);

      // Asynchronous reset in the middle of a replay
      send(1'b0, 64, 200, 1'b1, c);
      k = 0;
      while (!bus_a.tx_valid && (k < 20)) begin
         @(negedge clk);
         k++;
      end
      check("t6 tx started", 32'(bus_a.tx_valid), 1);
      repeat (5) @(negedge clk);
      #2 rstn_a = 1'b0;
      #1;
      check("t6 async tx_valid", 32'(bus_a.tx_valid), 0);
      check("t6 async tx_sof",   32'(bus_a.tx_sof), 0);
      check("t6 async tx_eof",   32'(bus_a.tx_eof), 0);
      check("t6 async tx_data",  32'(bus_a.tx_data), 0);
      check("t6 async fwd_cnt",  32'(fwd_a), 0);
      check("t6 async drop_cnt", 32'(drop_a), 0);
      repeat (2) @(negedge clk);
      rstn_a = 1'b1;
      swap_a = 1'b1;
      repeat (2) @(negedge clk);
      send(1'b0, 64, 220, 1'b1, c);
      wait_frames(1'b0, 5, 300, "t6 frame count");
      f = fr_a[4];
      check("t6 sof latency", f.sof_cyc - c, 3);
      check("t6 length", f.n, 64);
      check("t6 first bad byte", first_bad(1'b0, f.start, 64, 220, 1'b1), -1);
      check("t6 fwd_cnt", 32'(fwd_a), 1);
      check("t6 drop_cnt", 32'(drop_a), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
